// File: rtl/gate_settle_monitor.sv
// gate_settle_monitor: passes a gate-network bus on only after it holds steady for SETTLE cycles and flags buses that never settle
//   Optional osc_cnt port is enabled by the SETTLE_OSC_CNT_EN macro.
//   Ports:
//     SIM_CLK  - simulation clock
//     SIM_RST  - asynchronous active-low reset
//     d        - raw gate bus
//     q        - last settled value
//     upd      - one-cycle acceptance pulse
//     stable   - FSM is in STABLE
//     osc      - FSM is in OSC
//     osc_cnt  - saturating count of OSC entries
module gate_settle_monitor #(
  parameter int WIDTH = 16,
  parameter int SETTLE = 4,
  parameter int TIMEOUT = 64,
  parameter logic [WIDTH-1:0] IV = '0
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             upd,
  output logic             stable,
  output logic             osc
`ifdef SETTLE_OSC_CNT_EN
  ,
  output logic [7:0]       osc_cnt
`endif
);
  localparam int RW = $clog2(SETTLE + 1);
  localparam int BW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] S_V = RW'(SETTLE);
  localparam logic [BW-1:0] T_V = BW'(TIMEOUT);
  typedef enum logic [1:0] {ST_STABLE, ST_SETTLING, ST_OSC} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] prev;
  logic [RW-1:0] run, run_nxt, run_inc;
  logic [BW-1:0] busy, busy_nxt, busy_inc;
  logic changed, accept;
  always_comb begin
    changed = d != prev;
    run_inc = changed ? '0 : run + RW'(1);
    busy_inc = busy == T_V ? busy : busy + BW'(1);
    state_nxt = state;
    run_nxt = run;
    busy_nxt = busy;
    accept = 1'b0;
    case (state)
      ST_STABLE: if (changed) begin
        state_nxt = ST_SETTLING;
        run_nxt = '0;
        busy_nxt = BW'(1);
      end
      ST_SETTLING: begin
        run_nxt = run_inc;
        busy_nxt = busy_inc;
        // a settle on the timeout edge takes priority over entering OSC
        if (run_inc == S_V) begin
          accept = 1'b1;
          state_nxt = ST_STABLE;
        end else if (busy_inc == T_V) state_nxt = ST_OSC;
      end
      ST_OSC: begin
        run_nxt = run_inc;
        if (run_inc == S_V) begin
          accept = 1'b1;
          state_nxt = ST_STABLE;
        end
      end
      default: state_nxt = ST_STABLE;
    endcase
  end
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state <= ST_STABLE;
      prev <= IV;
      q <= IV;
      upd <= 1'b0;
      run <= '0;
      busy <= '0;
    end else begin
      state <= state_nxt;
      prev <= d;
      upd <= accept;
      run <= run_nxt;
      busy <= busy_nxt;
      if (accept) q <= d;
    end
  end
`ifdef SETTLE_OSC_CNT_EN
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) osc_cnt <= '0;
    else if (state != ST_OSC && state_nxt == ST_OSC && osc_cnt != 8'hff) osc_cnt <= osc_cnt + 8'd1;
  end
`endif
  assign stable = state == ST_STABLE;
  assign osc = state == ST_OSC;
endmodule

// File: tb/tb_gate_settle_monitor.sv
// tb_gate_settle_monitor: directed self-checking bench for gate_settle_monitor
module tb_gate_settle_monitor;
  logic SIM_CLK = 1'b0;
  logic SIM_RST = 1'b0;
  logic [15:0] d = 16'h1234;
  logic [15:0] qa, qb, qc;
  logic ua, ub, uc, sa, sb, sc, oa, ob, oc;
`ifdef SETTLE_OSC_CNT_EN
  logic [7:0] ca, cb, cc;
`endif
  int checks = 0;
  int errors = 0;
  always #5 SIM_CLK = ~SIM_CLK;
  gate_settle_monitor #(.WIDTH(16), .SETTLE(4), .TIMEOUT(64)) u_a (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .d(d), .q(qa), .upd(ua), .stable(sa), .osc(oa)
`ifdef SETTLE_OSC_CNT_EN
    , .osc_cnt(ca)
`endif
  );
  gate_settle_monitor #(.WIDTH(16), .SETTLE(4), .TIMEOUT(8)) u_b (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .d(d), .q(qb), .upd(ub), .stable(sb), .osc(ob)
`ifdef SETTLE_OSC_CNT_EN
    , .osc_cnt(cb)
`endif
  );
  gate_settle_monitor #(.WIDTH(16), .SETTLE(1), .TIMEOUT(8)) u_c (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .d(d), .q(qc), .upd(uc), .stable(sc), .osc(oc)
`ifdef SETTLE_OSC_CNT_EN
    , .osc_cnt(cc)
`endif
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge SIM_CLK);
    #1;
  endtask
  initial begin
    #2;
    check("rst_q", qa, 16'h0000);
    check("rst_upd", ua, 0);
    check("rst_osc", oa, 0);
    check("rst_stable", sa, 1);
    check("rst_stable_c", sc, 1);
    check("rst_osc_c", oc, 0);
    repeat (2) step;
    check("rst_hold_q", qa, 16'h0000);
    SIM_RST = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step;
      check("first_upd", ua, e == 5);
      check("first_q", qa, e >= 5 ? 16'h1234 : 16'h0000);
      check("s1_upd", uc, e == 2);
      if (e == 1) check("first_stable", sa, 0);
    end
    check("s1_q", qc, 16'h1234);
    check("s1_stable", sb, 1);
    d = 16'h0000;
    repeat (6) step;
    check("pre_glitch_q", qa, 16'h0000);
    d = 16'h0001;
    step;
    check("glitch_upd0", ua, 0);
    d = 16'h0000;
    for (int k = 1; k <= 6; k++) begin
      step;
      check("glitch_upd", ua, k == 5);
    end
    check("glitch_q", qa, 16'h0000);
    d = 16'h0005;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) d = 16'h0006;
      step;
      check("restart_upd", ua, k == 6);
    end
    check("restart_q", qa, 16'h0006);
    for (int i = 0; i < 100; i++) begin
      d = i[0] ? 16'hAAAA : 16'h5555;
      step;
      if (i == 62 || i == 63) check("osc_rise", oa, i == 63);
      if (i == 6 || i == 7) check("osc_rise_b", ob, i == 7);
      if (i == 99) check("osc_q_hold", qa, 16'h0006);
    end
    for (int k = 1; k <= 4; k++) begin
      step;
      check("osc_fall", oa, k < 4);
      check("osc_upd", ua, k == 4);
    end
    check("osc_q", qa, 16'hAAAA);
    check("osc_stable", sa, 1);
`ifdef SETTLE_OSC_CNT_EN
    check("osc_cnt", {8'h00, ca}, 16'h0001);
`endif
    d = 16'h0001;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) d = 16'h0002;
      step;
      check("bnd_osc", ob, 0);
      check("bnd_upd", ub, k == 7);
    end
    check("bnd_q", qb, 16'h0002);
    d = 16'h0007;
    repeat (2) step;
    check("mid_settling", sa, 0);
    #2 SIM_RST = 1'b0;
    #1;
    check("mid_rst_q", qa, 16'h0000);
    check("mid_rst_upd", ua, 0);
    check("mid_rst_stable", sa, 1);
    check("mid_rst_osc", oa, 0);
`ifdef SETTLE_OSC_CNT_EN
    check("mid_rst_cnt", {8'h00, ca}, 16'h0000);
`endif
    d = 16'h0000;
    repeat (2) step;
    SIM_RST = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step;
      check("post_rst_upd", ua, 0);
    end
    check("post_rst_q", qa, 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gate_settle_monitor.md
# gate_settle_monitor

Downstream consumer for the emulated gate network. It watches a bus of gate outputs that update on SIM_CLK. It only passes a value on to synchronous FPGA logic (DSKY drivers, I/O channel latches) once that value has held steady for a programmable number of SIM_CLK cycles. It also flags buses that fail to settle, which indicates a combinational loop ringing inside the gate emulation.

## Interface
Parameters:
- WIDTH, 16, width of monitored bus.
- SETTLE, 4, consecutive unchanged samples required to accept a value; legal range 1..255.
- TIMEOUT, 64, cycles in SETTLING before declaring oscillation; must be > SETTLE, max 65535.
- IV, {WIDTH{1'b0}}, reset value of captured output and of the internal history register.

Ports:
- SIM_CLK, input, 1, simulation clock; all state updates on posedge.
- SIM_RST, input, 1, asynchronous active-low reset.
- d, input, WIDTH, raw gate-network bus.
- q, output, WIDTH, last settled value.
- upd, output, 1, one-cycle pulse when q takes a new settled value.
- stable, output, 1, high when the FSM is in STABLE.
- osc, output, 1, high while the FSM is in OSC.
- osc_cnt, output, 8, saturating count of OSC entries; present only with SETTLE_OSC_CNT_EN.

## Operation
- Sampling, every posedge:
  - changed = (d != prev).
  - prev <= d.
- Counters:
  - run_cnt: ceil(log2(SETTLE+1)) bits, counts consecutive unchanged samples.
  - busy_cnt: ceil(log2(TIMEOUT+1)) bits, saturating.
- STABLE:
  - If changed: go to SETTLING, run_cnt <= 0, busy_cnt <= 1.
  - Otherwise hold.
- SETTLING:
  - busy_cnt increments each cycle.
  - If changed: run_cnt <= 0. Otherwise run_cnt increments.
  - If the unchanged sample makes run_cnt reach SETTLE: q <= d, upd <= 1, go to STABLE.
  - Otherwise, if busy_cnt reaches TIMEOUT: go to OSC, osc <= 1.
  - Settle and timeout in the same cycle: settle wins; OSC is not entered.
- OSC:
  - q is held and busy_cnt is frozen.
  - run_cnt behaves as in SETTLING.
  - When run_cnt reaches SETTLE: q <= d, upd <= 1, osc <= 0, go to STABLE.
- upd:
  - Pulses on every acceptance, even if the new q equals the old q. This covers a glitch that returns to its original value.
- Reset (asserted asynchronously, takes effect immediately):
  - q = IV, prev = IV, upd = 0, osc = 0, stable = 1.
  - Both counters 0; state STABLE; osc_cnt = 0.
  - Reset mid-SETTLING or mid-OSC discards the pending value; no upd is generated.
- After reset release, if d != IV, the first posedge enters SETTLING normally.

## Timing
- Latency: new value first sampled at edge N; if unchanged at edges N+1..N+SETTLE, q updates and upd is high after edge N+SETTLE. Latency is SETTLE cycles from first sample.
- SETTLE=1 accepts after one confirming sample.
- A change at edge N+k (k ≤ SETTLE) restarts the settle window from that edge.
- osc asserts after edge N+TIMEOUT-1 when no settle has occurred; it deasserts on the accepting edge.
- All outputs are registered; there is no combinational path from d.

## Configuration
- SETTLE_OSC_CNT_EN defined:
  - osc_cnt port exists.
  - It increments on each STABLE/SETTLING→OSC transition and saturates at 255.
  - Cleared only by reset.
- Not defined: the osc_cnt port and its register are absent; all other behaviour is identical.

## Test plan
- Reset check: hold SIM_RST=0 with d=16'h1234 → q=IV(0), upd=0, osc=0, stable=1. Release; d stays at 16'h1234 → q=16'h1234 with upd pulse 4 cycles after first sample.
- Glitch: d=0x0000, pulse d=0x0001 for 1 cycle, then back to 0x0000 → one upd pulse with q remains 0x0000, 4 cycles after the glitch returns.
- Restart: change d at edges 10 and 12, then hold → q updates after edge 16, single upd.
- Oscillation: toggle d every cycle for 100 cycles with TIMEOUT=64 → osc rises after edge N+63; stop toggling → q updates and osc falls 4 edges later; osc_cnt=1 (macro on).
- Boundary: settle completes on the same edge busy_cnt hits TIMEOUT (SETTLE=4, TIMEOUT=8, changes at N and N+3) → upd=1, osc stays 0.
- Reset mid-operation: assert SIM_RST during SETTLING → q returns to IV immediately, no upd, osc_cnt cleared.
